sgb_mem_arbiter: RTL
====================

Name: sgb_mem_arbiter

Overview:
- Shares one 16-bit external ROM/SDRAM port between three requesters:
  - cartridge/boot download writes
  - SNES-side SGB BIOS ROM reads
  - Game Boy cart ROM reads
- Sits between the SGB mapping layer (SNES rom_addr/rom_oe_n, GB gb_rom_addr/gb_rom_rd, ioctl download bus) and the memory controller.
- Fixed priority: download > SNES > GB. A starvation guard keeps the GB core from being locked out.

Parameters:
- SNES_BASE, 25'h0000000, byte base address of SNES BIOS region in memory.
- GB_BASE, 25'h0400000, byte base address of GB cart region.
- MAX_SNES_STREAK, 4, consecutive SNES grants allowed while GB is pending before GB wins.
- TIMEOUT, 64, mem_ack watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- snes_rd  in  1  one-cycle read strobe
- snes_addr  in  24  SNES ROM byte address
- snes_q  out  16  read data, held until next SNES completion
- snes_valid  out  1  one-cycle pulse: snes_q updated
- gb_rd  in  1  one-cycle read strobe
- gb_addr  in  23  GB ROM byte address
- gb_q  out  8  read byte, held
- gb_valid  out  1  one-cycle pulse: gb_q updated
- io_wr  in  1  one-cycle download write strobe
- io_addr  in  25  download byte address (word aligned, bit0 ignored)
- io_dat  in  16  download data
- io_gb_cart  in  1  1 = download targets GB region, 0 = SNES region
- io_ovf  out  1  sticky: a download write was dropped
- mem_req  out  1  request; held until mem_ack
- mem_we  out  1  write enable, stable while mem_req
- mem_addr  out  25  byte address, stable while mem_req
- mem_din  out  16  write data
- mem_ack  in  1  one-cycle completion; mem_q valid same cycle
- mem_q  in  16  read data
- arb_err  out  1  sticky watchdog error (tied 0 without the optional feature)

Behaviour:
- Reset values:
  - mem_req, mem_we, snes_valid, gb_valid, io_ovf, arb_err = 0
  - mem_addr, mem_din, snes_q, gb_q = 0
  - all pending slots empty; streak counter = 0; FSM = IDLE
- Pending slots, one per requester:
  - A strobe sets the slot and latches its address/data on the next clk.
  - Read strobe into a full, not-yet-granted slot: overwrite, latest wins, no flag.
  - io_wr into a full slot: write dropped, io_ovf set; cleared only by reset.
  - The slot frees at grant (contents copied to the transaction registers), so a strobe during an in-flight access fills the slot normally.
  - A strobe on the same cycle the slot is granted refills the slot.
- FSM states: IDLE, ACCESS.
  - IDLE → ACCESS when any slot is pending.
    - Arbitration: io > SNES > GB.
    - Exception: GB beats SNES when GB is pending and streak == MAX_SNES_STREAK.
    - Registers mem_req=1, mem_addr, mem_we, mem_din.
  - ACCESS holds all mem_* outputs stable until mem_ack.
    - On mem_ack: mem_req=0 next cycle, FSM → IDLE.
    - SNES: snes_q <= mem_q, snes_valid pulses.
    - GB: gb_q <= gb_addr[0] ? mem_q[15:8] : mem_q[7:0], gb_valid pulses.
    - io: no response.
- Address math, truncated to 25 bits (wraps at 32 MiB):
  - SNES: SNES_BASE + snes_addr.
  - GB: GB_BASE + gb_addr with bit0 forced 0.
  - io: io_gb_cart selects the base; base + {io_addr[24:1],1'b0}.
- Streak counter:
  - +1 on each SNES grant while GB is pending, saturating at MAX_SNES_STREAK.
  - Cleared on GB grant, or on any cycle GB is not pending.
- Latency:
  - Strobe at cycle t → mem_req at t+2 if the FSM is idle.
  - mem_ack at cycle a → valid pulse at a+1.
  - Next grant evaluated at a+1; mem_req re-asserted at a+2 at the earliest.
  - mem_req is therefore low for at least one cycle between accesses.
- reset mid-ACCESS: mem_req drops the next cycle, slots are cleared, no valid pulse. The memory controller must tolerate an abandoned request.

Optional Feature:
- Macro: SGB_MEM_ARB_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in ACCESS.
  - When it reaches TIMEOUT without mem_ack, the access aborts.
  - Reads complete with data 16'hFFFF (GB byte 8'hFF) and a valid pulse; writes are discarded.
  - arb_err is set (sticky) and the FSM → IDLE.
- Undefined: no counter; ACCESS waits indefinitely; arb_err tied 0.

Test Plan:
- Single SNES read: snes_rd, snes_addr=24'h000123, ack 3 cycles after mem_req, mem_q=16'hBEEF → mem_addr=SNES_BASE+24'h000123, mem_we=0, snes_valid 1 cycle after ack, snes_q=16'hBEEF.
- GB byte select: gb_addr=23'h000005, mem_q=16'hA55A → mem_addr=GB_BASE+4, gb_q=8'hA5; repeat with gb_addr=4 → gb_q=8'h5A.
- Simultaneous io_wr (io_addr=25'h10, io_dat=16'h1234, io_gb_cart=1), snes_rd and gb_rd in one cycle → grant order io (mem_we=1, mem_addr=GB_BASE+25'h10, mem_din=16'h1234), then SNES, then GB.
- Starvation: GB pending while SNES re-strobes every access with MAX_SNES_STREAK=4 → exactly 4 SNES grants, then GB granted, streak cleared.
- Overflow: two io_wr while the first is pending and not granted → second dropped, io_ovf=1 until reset; memory sees only the first write.
- Watchdog (macro defined, TIMEOUT=64): SNES read, mem_ack never asserted → at 64 cycles snes_valid pulses with snes_q=16'hFFFF, arb_err=1, mem_req=0 next cycle; a later GB read completes normally.

Source files
------------

// File: rtl/sgb_mem_arbiter.sv
// sgb_mem_arbiter: shares one 16-bit external ROM/SDRAM port between
// download writes, SNES SGB BIOS reads and Game Boy cart ROM reads.
// Fixed priority io > SNES > GB, with a streak guard that lets GB win
// after MAX_SNES_STREAK consecutive SNES grants while GB waits.
// Optional: define SGB_MEM_ARB_WATCHDOG_EN to abort accesses whose
// mem_ack does not arrive within TIMEOUT cycles (sets sticky arb_err).
module sgb_mem_arbiter #(
  parameter logic [24:0] SNES_BASE       = 25'h0000000,
  parameter logic [24:0] GB_BASE         = 25'h0400000,
  parameter int unsigned MAX_SNES_STREAK = 4,
  parameter int unsigned TIMEOUT         = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        snes_rd,
  input  logic [23:0] snes_addr,
  output logic [15:0] snes_q,
  output logic        snes_valid,
  input  logic        gb_rd,
  input  logic [22:0] gb_addr,
  output logic [7:0]  gb_q,
  output logic        gb_valid,
  input  logic        io_wr,
  input  logic [24:0] io_addr,
  input  logic [15:0] io_dat,
  input  logic        io_gb_cart,
  output logic        io_ovf,
  output logic        mem_req,
  output logic        mem_we,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic        mem_ack,
  input  logic [15:0] mem_q,
  output logic        arb_err
);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;
  typedef enum logic [1:0] {SRC_IO, SRC_SNES, SRC_GB} src_t;

  localparam int unsigned   SW         = $clog2(MAX_SNES_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_SNES_STREAK);

  state_t        state, state_nx;
  logic          io_pend, snes_pend, gb_pend;
  logic [23:0]   io_waddr_r;
  logic [15:0]   io_dat_r;
  logic          io_gb_r;
  logic [23:0]   snes_addr_r;
  logic [22:0]   gb_addr_r;
  logic [SW-1:0] streak;
  src_t          tx_src;
  logic          tx_gb_hi;
  logic          grant_io, grant_snes, grant_gb, gb_first;
  logic          done, abort;
  logic [24:0]   snes_maddr, gb_maddr, io_maddr;
  logic [15:0]   rd_data;
  logic          unused_ok;

  assign snes_maddr = SNES_BASE + {1'b0, snes_addr_r};
  assign gb_maddr   = GB_BASE + {2'b00, gb_addr_r[22:1], 1'b0};
  assign io_maddr   = (io_gb_r ? GB_BASE : SNES_BASE) + {io_waddr_r, 1'b0};
  assign gb_first   = gb_pend && (streak == STREAK_MAX);
  // An aborted read returns all ones.
  assign rd_data    = mem_ack ? mem_q : '1;
  assign unused_ok  = &{1'b0, io_addr[0]};

`ifdef SGB_MEM_ARB_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;

  assign abort = (state == ST_ACCESS) && !mem_ack && (wd_cnt == WDW'(TIMEOUT - 1));

  // Watchdog: counts cycles spent waiting in ACCESS.
  always_ff @(posedge clk) begin
    if (reset || state != ST_ACCESS) wd_cnt <= '0;
    else                             wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky error flag raised on any aborted access.
  always_ff @(posedge clk) begin
    if (reset)      arb_err <= 1'b0;
    else if (abort) arb_err <= 1'b1;
  end
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
  assign abort   = 1'b0;
  assign arb_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state and grant selection.
  always_comb begin
    state_nx   = state;
    grant_io   = 1'b0;
    grant_snes = 1'b0;
    grant_gb   = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (io_pend)                     grant_io   = 1'b1;
        else if (snes_pend && !gb_first) grant_snes = 1'b1;
        else if (gb_pend)                grant_gb   = 1'b1;
        if (io_pend || snes_pend || gb_pend) state_nx = ST_ACCESS;
      end
      ST_ACCESS: begin
        done = mem_ack || abort;
        if (done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Pending slots: a strobe on the grant cycle takes precedence over the free.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_pend     <= 1'b0;
      snes_pend   <= 1'b0;
      gb_pend     <= 1'b0;
      io_ovf      <= 1'b0;
      io_waddr_r  <= '0;
      io_dat_r    <= '0;
      io_gb_r     <= 1'b0;
      snes_addr_r <= '0;
      gb_addr_r   <= '0;
    end else begin
      if (io_wr) begin
        if (io_pend && !grant_io) begin
          io_ovf <= 1'b1;
        end else begin
          io_pend    <= 1'b1;
          io_waddr_r <= io_addr[24:1];
          io_dat_r   <= io_dat;
          io_gb_r    <= io_gb_cart;
        end
      end else if (grant_io) begin
        io_pend <= 1'b0;
      end
      if (snes_rd) begin
        snes_pend   <= 1'b1;
        snes_addr_r <= snes_addr;
      end else if (grant_snes) begin
        snes_pend <= 1'b0;
      end
      if (gb_rd) begin
        gb_pend   <= 1'b1;
        gb_addr_r <= gb_addr;
      end else if (grant_gb) begin
        gb_pend <= 1'b0;
      end
    end
  end

  // Consecutive SNES grants while GB waits, saturating.
  always_ff @(posedge clk) begin
    if (reset || grant_gb || !gb_pend) streak <= '0;
    else if (grant_snes && streak != STREAK_MAX) streak <= streak + 1'b1;
  end

  // Memory transaction registers and read responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      snes_q     <= '0;
      snes_valid <= 1'b0;
      gb_q       <= '0;
      gb_valid   <= 1'b0;
      tx_src     <= SRC_IO;
      tx_gb_hi   <= 1'b0;
    end else begin
      snes_valid <= 1'b0;
      gb_valid   <= 1'b0;
      if (state == ST_IDLE) begin
        if (grant_io) begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b1;
          mem_addr <= io_maddr;
          mem_din  <= io_dat_r;
          tx_src   <= SRC_IO;
        end else if (grant_snes) begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= snes_maddr;
          tx_src   <= SRC_SNES;
        end else if (grant_gb) begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= gb_maddr;
          tx_src   <= SRC_GB;
          tx_gb_hi <= gb_addr_r[0];
        end
      end else if (done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (tx_src == SRC_SNES) begin
          snes_q     <= rd_data;
          snes_valid <= 1'b1;
        end else if (tx_src == SRC_GB) begin
          gb_q     <= tx_gb_hi ? rd_data[15:8] : rd_data[7:0];
          gb_valid <= 1'b1;
        end
      end
    end
  end

endmodule
